key_scan: RTL and testbench

KEY_SCAN -- requirements
Module: key_scan

---
 rtl/key_scan_pkg.sv | 39 +++
 rtl/key_sync.sv | 27 ++
 rtl/key_scan.sv | 136 +++++++++++++
 tb/tb_key_scan.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_scan_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Holds the scanner state enum, matrix dimensions and the row-probe helper.
package key_scan_pkg;

  localparam int KEY_W = 4;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int IDX_W = 2;

  // Column 0 driven low, all other columns released.
  localparam logic [COLS-1:0] COL_RESET = 4'b1110;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HOLD,
    ST_RELEASE
  } state_t;

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
  } probe_t;

  // A press is only meaningful when exactly one row reads low.
  function automatic probe_t single_low(input logic [ROWS-1:0] r);
    probe_t p;
    p.hit = 1'b0;
    p.idx = '0;
    if ($countones(~r) == 1) begin
      p.hit = 1'b1;
      for (int i = 0; i < ROWS; i++) begin
        if (!r[i]) p.idx = IDX_W'(i);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for asynchronous inputs, parameterized width.
// Resets to RESET_VAL so an idle pulled-up bus reads as released.
module key_sync #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: non-blocking assignments make q take the pre-edge value of meta,
  // giving two real flop stages instead of one collapsed wire.
  always_ff @(posedge clk) begin
    if (rstn) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_scan.sv
// 4x4 keypad scanner: rotates an active-low column drive, debounces a
// single-key press and its release, and reports the accepted key code.
module key_scan
  import key_scan_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic [ROWS-1:0]  row,
  output logic [COLS-1:0]  col,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_held
);

  localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);

  logic [ROWS-1:0]  row_s;
  state_t           state, state_next;
  logic [IDX_W-1:0] col_idx;
  logic [IDX_W-1:0] row_idx;
  logic [ROWS-1:0]  row_pat;
  logic [CNT_W-1:0] cnt;
  probe_t           probe;
  logic             cnt_last;

  logic latch, cnt_clr, cnt_inc, col_adv, accept, release_done;

  key_sync #(
    .WIDTH     (ROWS),
    .RESET_VAL ('1)
  ) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (row),
    .q    (row_s)
  );

  assign probe    = single_low(row_s);
  assign cnt_last = (cnt == CNT_W'(DEBOUNCE_TICKS - 1));

  always_ff @(posedge clk) begin
    if (rstn) state <= ST_SCAN;
    else      state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    latch        = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    col_adv      = 1'b0;
    accept       = 1'b0;
    release_done = 1'b0;
    if (enable) begin
      unique case (state)
        ST_SCAN: begin
          if (probe.hit) begin
            latch      = 1'b1;
            cnt_clr    = 1'b1;
            state_next = ST_DEBOUNCE;
          end else begin
            col_adv = 1'b1;
          end
        end
        ST_DEBOUNCE: begin
          if (row_s == row_pat) begin
            cnt_inc = 1'b1;
            if (cnt_last) begin
              accept     = 1'b1;
              state_next = ST_HOLD;
            end
          end else begin
            col_adv    = 1'b1;
            state_next = ST_SCAN;
          end
        end
        ST_HOLD: begin
          // Only the latched row matters; other keys in that column are ignored.
          if (row_s[row_idx]) begin
            cnt_clr    = 1'b1;
            state_next = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (row_s[row_idx]) begin
            cnt_inc = 1'b1;
            if (cnt_last) begin
              release_done = 1'b1;
              col_adv      = 1'b1;
              state_next   = ST_SCAN;
            end
          end else begin
            cnt_clr = 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    col = ~(~COL_RESET << col_idx);
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      col_idx   <= '0;
      row_idx   <= '0;
      row_pat   <= '1;
      cnt       <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      // Pulse for the acceptance clock only, regardless of enable spacing.
      key_valid <= accept;
      if (col_adv) col_idx <= col_idx + 1'b1;
      if (latch) begin
        row_idx <= probe.idx;
        row_pat <= row_s;
      end
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
      if (accept) begin
        key_code <= {row_idx, col_idx};
        key_held <= 1'b1;
      end
      if (release_done) key_held <= 1'b0;
    end
  end

endmodule

// File: tb/tb_key_scan.sv
// Self-checking bench for key_scan: a keypad model drives the rows from the
// DUT's column drive, and a tick-level reference model predicts all outputs.
module tb_key_scan;

  localparam int DT = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] press_mask;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: which column is scanned, and what the scanner is doing.
  int         m_col;
  bit         m_pend;
  bit         m_held;
  bit         m_rel;
  int         m_run;
  int         m_row;
  logic [3:0] m_pat;
  logic [3:0] m_code;
  bit         m_valid;

  always #5 clk = ~clk;

  key_scan #(.DEBOUNCE_TICKS(DT)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .enable    (enable),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  // Physical keypad: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (press_mask[r*4+c] && col[c] === 1'b0) row[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_col();
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << m_col);
  endfunction

  function automatic logic [3:0] exp_pattern();
    logic [3:0] p;
    p = 4'hF;
    for (int r = 0; r < 4; r++) if (press_mask[r*4+m_col]) p[r] = 1'b0;
    return p;
  endfunction

  task automatic model_reset();
    m_col = 0; m_pend = 0; m_held = 0; m_rel = 0; m_run = 0;
    m_row = 0; m_pat = 4'hF; m_code = 4'h0; m_valid = 0;
  endtask

  task automatic model_step(input logic [3:0] p);
    m_valid = 0;
    if (!m_pend && !m_held) begin
      if ($countones(~p) == 1) begin
        m_pat = p; m_run = 0; m_pend = 1;
        for (int r = 0; r < 4; r++) if (!p[r]) m_row = r;
      end else begin
        m_col = (m_col + 1) % 4;
      end
    end else if (m_pend) begin
      if (p == m_pat) begin
        m_run++;
        if (m_run == DT) begin
          m_code = 4'(m_row * 4 + m_col);
          m_valid = 1; m_held = 1; m_pend = 0; m_rel = 0;
        end
      end else begin
        m_pend = 0;
        m_col = (m_col + 1) % 4;
      end
    end else if (!m_rel) begin
      if (p[m_row]) begin m_rel = 1; m_run = 0; end
    end else if (p[m_row]) begin
      m_run++;
      if (m_run == DT) begin
        m_held = 0; m_rel = 0;
        m_col = (m_col + 1) % 4;
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_col"},   col,       exp_col());
    check({tag, "_valid"}, {3'b0, key_valid}, {3'b0, m_valid});
    check({tag, "_held"},  {3'b0, key_held},  {3'b0, m_held});
    check({tag, "_code"},  key_code,  m_code);
  endtask

  // One scan tick, spaced so the row change has crossed the synchronizer.
  task automatic tick(input string tag, inout int pulses);
    logic [3:0] p;
    repeat (2) @(negedge clk);
    p = exp_pattern();
    model_step(p);
    @(negedge clk) enable = 1'b1;
    @(negedge clk) enable = 1'b0;
    check_outputs(tag);
    if (key_valid === 1'b1) pulses++;
    @(negedge clk);
    check({tag, "_pulse_end"}, {3'b0, key_valid}, 4'h0);
    check({tag, "_col_hold"},  col, exp_col());
    @(negedge clk);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    rstn   = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    rstn   = 1'b0;
    enable = 1'b0;
    model_reset();
    check_outputs(tag);
  endtask

  initial begin
    int pulses;
    rstn = 1'b1; enable = 1'b0; press_mask = '0;
    model_reset();
    repeat (3) @(negedge clk);
    apply_reset("reset");

    // Idle rotation, no key.
    pulses = 0;
    for (int i = 0; i < 8; i++) tick("idle", pulses);
    check("idle_pulses", 4'(pulses), 4'd0);

    // Key 9 (row 2, col 1) held for 20 ticks, then released.
    pulses = 0;
    press_mask = 16'h0200;
    for (int i = 0; i < 20; i++) tick("key9", pulses);
    check("key9_pulses", 4'(pulses), 4'd1);
    check("key9_code", key_code, 4'h9);
    check("key9_held", {3'b0, key_held}, 4'h1);
    press_mask = '0;
    for (int i = 0; i < 6; i++) tick("key9_rel", pulses);
    check("key9_released", {3'b0, key_held}, 4'h0);

    // Press bounce: reach col 1, then low 2 ticks, high 1, then stable.
    pulses = 0;
    while (m_col != 1) tick("bounce_align", pulses);
    press_mask = 16'h0200;
    tick("bounce_lo", pulses);
    tick("bounce_lo", pulses);
    press_mask = '0;
    tick("bounce_hi", pulses);
    press_mask = 16'h0200;
    for (int i = 0; i < 14; i++) tick("bounce_stable", pulses);
    check("bounce_pulses", 4'(pulses), 4'd1);
    check("bounce_code", key_code, 4'h9);

    // Release bounce: open 2 ticks, re-close 1, then open cleanly.
    press_mask = '0;
    tick("relb_open", pulses);
    tick("relb_open", pulses);
    press_mask = 16'h0200;
    tick("relb_close", pulses);
    press_mask = '0;
    for (int i = 0; i < 4; i++) tick("relb_clean", pulses);
    check("relb_pulses", 4'(pulses), 4'd1);
    check("relb_held_clear", {3'b0, key_held}, 4'h0);

    // Rows 0 and 3 on column 0 together: ghost, never latched.
    pulses = 0;
    press_mask = 16'h1001;
    for (int i = 0; i < 8; i++) tick("multi", pulses);
    check("multi_pulses", 4'(pulses), 4'd0);
    press_mask = '0;

    // Reset during HOLD.
    apply_reset("pre_hold");
    pulses = 0;
    press_mask = 16'h0200;
    for (int i = 0; i < 8; i++) tick("to_hold", pulses);
    press_mask = '0;
    apply_reset("rst_hold");

    // Reset at debounce count 3.
    press_mask = 16'h0200;
    for (int i = 0; i < 5; i++) tick("to_deb3", pulses);
    check("deb3_no_valid", {3'b0, key_held}, 4'h0);
    press_mask = '0;
    apply_reset("rst_deb3");

    // Randomized presses with bounce, second keys and variable hold time.
    for (int ep = 0; ep < 40; ep++) begin
      logic [15:0] base;
      int hold_n;
      base = 16'h0001 << $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) base = base | (16'h0001 << $urandom_range(0, 15));
      hold_n = $urandom_range(1, 12);
      for (int i = 0; i < hold_n; i++) begin
        press_mask = ($urandom_range(0, 4) == 0) ? 16'h0 : base;
        tick("rnd_press", pulses);
      end
      press_mask = '0;
      for (int i = 0; i < int'($urandom_range(1, 8)); i++) tick("rnd_rel", pulses);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
